// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default clocking constants, bit-period helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_CLK_FREQ_HZ = 25000000;
    localparam int UART_BAUD_RATE   = 115200;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_t;

    // Clock cycles per serial bit, rounded to the nearest integer.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Latency: 2 clk from input change to q.
// Backpressure: none; level signal, always follows the input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both load the reset value so q shows the chosen idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_stream.sv
// UART 8N1 receiver presenting each byte on a valid/ready stream with sticky framing/overrun flags.
// Latency: t_valid_o rises 1 clk after the mid-stop-bit sample (~9.5 bit times + 2 sync cycles from start edge).
// Backpressure: single holding register; a byte arriving while it is full and not being accepted is dropped and flags overrun.
module uart_rx_stream
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = UART_CLK_FREQ_HZ,
    parameter int BAUD_RATE   = UART_BAUD_RATE,
    parameter int DATA_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 t_valid_o,
    input  logic                 t_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    input  logic                 clr_status_i,
    output logic                 busy_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic [1:0]           flush_cnt;
    logic                 armed;
    uart_state_t          state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rx_s)
    );

    // A start bit only counts once the synchronizer holds real line data and the line has been seen idle,
    // so a line still low when reset releases is not mistaken for a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= 2'd0;
            armed     <= 1'b0;
        end else if (flush_cnt != 2'd2) begin
            flush_cnt <= flush_cnt + 2'd1;
        end else if (rx_s) begin
            armed <= 1'b1;
        end
    end

    // Receive FSM with baud/bit counters, shift register, holding register and sticky status.
    // Later assignments override earlier ones: a new load beats the acceptance clear, a flag set beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            data_o      <= '0;
            t_valid_o   <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (t_valid_o && t_ready_i) begin
                t_valid_o <= 1'b0;
            end
            if (clr_status_i) begin
                frame_err_o <= 1'b0;
                overrun_o   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (armed && !rx_s) begin
                        state  <= START;
                        busy_o <= 1'b1;
                    end
                end

                START: begin
                    if (baud_cnt == BAUD_HALF) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            if (!t_valid_o || t_ready_i) begin
                                data_o    <= shreg;
                                t_valid_o <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench for uart_rx_stream: serial frames in, stream bytes and status flags checked.
// Latency: n/a.
// Backpressure: t_ready_i driven by the scenarios.
module tb_uart_rx_stream;

    localparam int BIT_T = 217;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic [7:0] data_o;
    logic       t_valid_o;
    logic       t_ready_i = 1'b1;
    logic       frame_err_o;
    logic       overrun_o;
    logic       clr_status_i = 1'b0;
    logic       busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx_stream dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .t_valid_o    (t_valid_o),
        .t_ready_i    (t_ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .clr_status_i (clr_status_i),
        .busy_o       (busy_o)
    );

    always #20 clk = ~clk;

    // Capture every accepted byte, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst && t_valid_o && t_ready_i) got_q.push_back(data_o);
    end

    // Inputs change 5 time units after the rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #5;
    endtask

    // Drive one serial frame: start bit, LSB-first data, stop bit of the given level.
    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_v);
        rx_i = 1'b0;
        wait_cyc(cpb);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            wait_cyc(cpb);
        end
        rx_i = stop_v;
        wait_cyc(cpb);
        if (stop_v) rx_i = 1'b1;
    endtask

    // Send one byte with the consumer always ready and compare against the model.
    task automatic recv_one(input logic [7:0] b, input int cpb, input string nm);
        logic [7:0] g;
        got_q.delete();
        exp_q.push_back(b);
        send_frame(b, cpb, 1'b1);
        wait_cyc(cpb);
        @(negedge clk);
        n_checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL %s_count: got %0d bytes, want %0d", nm, got_q.size(), exp_q.size());
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            n_checks++;
            if (g !== exp_q[0]) $display("FAIL %s_data: got %02h want %02h", nm, g, exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
        end
        exp_q.delete();
        n_checks++;
        if ({frame_err_o, overrun_o} !== 2'b00)
            $display("FAIL %s_flags: got fe=%0b ov=%0b want 0 0", nm, frame_err_o, overrun_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rx_i = 1'($urandom);
            wait_cyc(1);
        end
        @(negedge clk);
        n_checks++;
        if ({data_o, t_valid_o, frame_err_o, overrun_o, busy_o} !== 12'h000)
            $display("FAIL reset_outputs: got data=%02h v=%0b fe=%0b ov=%0b busy=%0b want all 0",
                     data_o, t_valid_o, frame_err_o, overrun_o, busy_o);
        else n_pass++;
        rx_i = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(60);
        @(negedge clk);
        n_checks++;
        if ({busy_o, t_valid_o} !== 2'b00)
            $display("FAIL reset_idle: got busy=%0b v=%0b want 0 0", busy_o, t_valid_o);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [7:0] pat [4];
        pat[0] = 8'hAC; pat[1] = 8'h00; pat[2] = 8'hFF; pat[3] = 8'h55;
        t_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) recv_one(pat[i], BIT_T, "single");
    endtask

    task automatic test_overrun();
        got_q.delete();
        t_ready_i = 1'b0;
        send_frame(8'h3C, BIT_T, 1'b1);
        wait_cyc(BIT_T);
        send_frame(8'hA5, BIT_T, 1'b1);
        wait_cyc(BIT_T);
        @(negedge clk);
        n_checks++;
        if (data_o !== 8'h3C) $display("FAIL ovr_data: got %02h want 3c", data_o);
        else n_pass++;
        n_checks++;
        if ({t_valid_o, overrun_o, frame_err_o} !== 3'b110)
            $display("FAIL ovr_flags: got v=%0b ov=%0b fe=%0b want 1 1 0", t_valid_o, overrun_o, frame_err_o);
        else n_pass++;
        wait_cyc(1);
        t_ready_i = 1'b1;
        wait_cyc(1);
        t_ready_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (t_valid_o !== 1'b0) $display("FAIL ovr_accept: got v=%0b want 0", t_valid_o);
        else n_pass++;
        n_checks++;
        if (got_q.size() !== 1 || got_q[0] !== 8'h3C)
            $display("FAIL ovr_taken: got %0d bytes want one 3c", got_q.size());
        else n_pass++;
        got_q.delete();
        wait_cyc(1);
        clr_status_i = 1'b1;
        wait_cyc(1);
        clr_status_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (overrun_o !== 1'b0) $display("FAIL ovr_clear: got ov=%0b want 0", overrun_o);
        else n_pass++;
        t_ready_i = 1'b1;
    endtask

    task automatic test_frame_err();
        got_q.delete();
        send_frame(8'hC3, BIT_T, 1'b0);
        wait_cyc(3 * BIT_T);
        @(negedge clk);
        n_checks++;
        if ({frame_err_o, t_valid_o, busy_o} !== 3'b101)
            $display("FAIL ferr_state: got fe=%0b v=%0b busy=%0b want 1 0 1", frame_err_o, t_valid_o, busy_o);
        else n_pass++;
        n_checks++;
        if (got_q.size() !== 0) $display("FAIL ferr_nobyte: got %0d bytes want 0", got_q.size());
        else n_pass++;
        rx_i = 1'b1;
        wait_cyc(2 * BIT_T);
        send_frame(8'h96, BIT_T, 1'b1);
        wait_cyc(BIT_T);
        @(negedge clk);
        n_checks++;
        if (got_q.size() !== 1 || got_q[0] !== 8'h96)
            $display("FAIL ferr_recover: got %0d bytes want one 96", got_q.size());
        else n_pass++;
        n_checks++;
        if (frame_err_o !== 1'b1) $display("FAIL ferr_sticky: got fe=%0b want 1", frame_err_o);
        else n_pass++;
        got_q.delete();
        clr_status_i = 1'b1;
        wait_cyc(1);
        clr_status_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (frame_err_o !== 1'b0) $display("FAIL ferr_clear: got fe=%0b want 0", frame_err_o);
        else n_pass++;
    endtask

    task automatic test_glitch();
        got_q.delete();
        rx_i = 1'b0;
        wait_cyc(40);
        rx_i = 1'b1;
        wait_cyc(300);
        @(negedge clk);
        n_checks++;
        if ({busy_o, t_valid_o, frame_err_o, overrun_o} !== 4'b0000 || got_q.size() !== 0)
            $display("FAIL glitch: got busy=%0b v=%0b fe=%0b ov=%0b bytes=%0d want all 0",
                     busy_o, t_valid_o, frame_err_o, overrun_o, got_q.size());
        else n_pass++;
    endtask

    task automatic test_midframe_reset();
        logic [7:0] b;
        b = 8'hAC;
        got_q.delete();
        rx_i = 1'b0;
        wait_cyc(BIT_T);
        for (int i = 0; i < 4; i++) begin
            rx_i = b[i];
            wait_cyc(BIT_T);
        end
        rx_i = b[4];
        wait_cyc(100);
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1) $display("FAIL mid_busy: got busy=%0b want 1", busy_o);
        else n_pass++;
        wait_cyc(1);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy_o, t_valid_o, frame_err_o, overrun_o} !== 4'b0000)
            $display("FAIL mid_reset: got busy=%0b v=%0b fe=%0b ov=%0b want all 0",
                     busy_o, t_valid_o, frame_err_o, overrun_o);
        else n_pass++;
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(110);
        rx_i = 1'b1;
        wait_cyc(3 * BIT_T);
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || got_q.size() !== 0)
            $display("FAIL mid_noframe: got busy=%0b bytes=%0d want 0 0", busy_o, got_q.size());
        else n_pass++;
        recv_one(8'h5A, BIT_T, "mid_next");
    endtask

    task automatic test_tolerance();
        recv_one(8'hAC, 213, "tol_fast");
        recv_one(8'hAC, 221, "tol_slow");
    endtask

    // Back-to-back random bytes at slightly varied bit rates against a FIFO model.
    task automatic test_back_to_back();
        logic [7:0] b;
        logic [7:0] g;
        int n_exp;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, int'($urandom_range(215, 219)), 1'b1);
        end
        wait_cyc(BIT_T);
        @(negedge clk);
        n_exp = exp_q.size();
        n_checks++;
        if (got_q.size() !== n_exp) $display("FAIL b2b_count: got %0d want %0d", got_q.size(), n_exp);
        else n_pass++;
        for (int i = 0; i < n_exp; i++) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++;
            if (g !== exp_q[i]) $display("FAIL b2b_data%0d: got %02h want %02h", i, g, exp_q[i]);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_midframe_reset();
        test_tolerance();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
